alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 32-bit clocked ALU. It accepts operations from two independent requesters over valid/ready handshakes and drives one operation at a time into the ALU. It waits the ALU's fixed latency, then returns the captured result on a single tagged response channel. Illegal opcodes are rejected with an error response and never reach the ALU.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared clocked ALU: grants one
// operation at a time, waits the ALU latency, and returns a tagged response.
module alu_arbiter #(
   parameter int WIDTH       = 32,
   parameter int ALU_LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_operand1,
   input  logic [WIDTH-1:0] req0_operand2,
   input  logic [3:0]       req0_opcode,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_operand1,
   input  logic [WIDTH-1:0] req1_operand2,
   input  logic [3:0]       req1_opcode,
   output logic [WIDTH-1:0] alu_operand1,
   output logic [WIDTH-1:0] alu_operand2,
   output logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] CNT_LOAD = 3'(ALU_LATENCY);

   state_t           state;
   state_t           state_next;
   logic [2:0]       cnt;
   logic             last_grant;
   logic             grant_id;
   logic             accept;
   logic             sel_legal;
   logic [3:0]       sel_opcode;
   logic [WIDTH-1:0] sel_operand1;
   logic [WIDTH-1:0] sel_operand2;

   function automatic logic opcode_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1000: opcode_legal = 1'b1;
         default:                   opcode_legal = 1'b0;
      endcase
   endfunction

   // A lone requester always wins; on a tie the one not served last wins.
   assign grant_id     = req1_valid & (~req0_valid | ~last_grant);
   assign accept       = (state == IDLE) & (req0_valid | req1_valid);
   assign req0_ready   = accept & ~grant_id;
   assign req1_ready   = accept & grant_id;
   assign sel_opcode   = grant_id ? req1_opcode   : req0_opcode;
   assign sel_operand1 = grant_id ? req1_operand1 : req0_operand1;
   assign sel_operand2 = grant_id ? req1_operand2 : req0_operand2;
   assign sel_legal    = opcode_legal(sel_opcode);
   assign resp_valid   = (state == RESP);

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = sel_legal ? EXEC : RESP;
            end
         end
         EXEC: begin
            if (cnt == 3'd0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_operand1 <= '0;
         alu_operand2 <= '0;
         alu_opcode   <= 4'b0000;
         resp_id      <= 1'b0;
         resp_result  <= '0;
         resp_error   <= 1'b0;
         cnt          <= 3'd0;
         last_grant   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  resp_id <= grant_id;
                  if (sel_legal) begin
                     alu_operand1 <= sel_operand1;
                     alu_operand2 <= sel_operand2;
                     alu_opcode   <= sel_opcode;
                     last_grant   <= grant_id;
                     cnt          <= CNT_LOAD;
                  end else begin
                     // Rejected ops never touch the ALU or the fairness pointer.
                     resp_error  <= 1'b1;
                     resp_result <= '0;
                  end
               end
            end
            EXEC: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  resp_result <= alu_result;
                  resp_error  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a latency-1 instance for the main features
// and a latency-3 instance for the parameterised timing.
module tb_alu_arbiter;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_operand1, req0_operand2, req1_operand1, req1_operand2;
   logic [3:0]  req0_opcode, req1_opcode, alu_opcode;
   logic [31:0] alu_operand1, alu_operand2, alu_result, resp_result;
   logic        resp_valid, resp_ready, resp_id, resp_error;

   logic        l3_req0_valid, l3_req0_ready, l3_req1_valid, l3_req1_ready;
   logic [31:0] l3_req0_operand1, l3_req0_operand2, l3_req1_operand1, l3_req1_operand2;
   logic [3:0]  l3_req0_opcode, l3_req1_opcode, l3_alu_opcode;
   logic [31:0] l3_alu_operand1, l3_alu_operand2, l3_alu_result, l3_resp_result;
   logic        l3_resp_valid, l3_resp_ready, l3_resp_id, l3_resp_error;
   logic [31:0] l3_pipe [3];

   typedef struct packed {
      logic        id;
      logic        error;
      logic [31:0] result;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: alu_fn = a + b;
         4'b0001: alu_fn = a << b[4:0];
         4'b0100: alu_fn = a ^ b;
         4'b0101: alu_fn = a >> b[4:0];
         4'b0110: alu_fn = a | b;
         4'b0111: alu_fn = a & b;
         4'b1000: alu_fn = a - b;
         default: alu_fn = 32'hdead_beef;
      endcase
   endfunction

   function automatic logic legal_op(input logic [3:0] op);
      legal_op = (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0100) || (op == 4'b0101) ||
                 (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1000);
   endfunction

   function automatic exp_t make_exp(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      make_exp.id     = id;
      make_exp.error  = !legal_op(op);
      make_exp.result = legal_op(op) ? alu_fn(op, a, b) : 32'd0;
   endfunction

   // ALU models: latency 1 and latency 3
   always_ff @(posedge clock) alu_result <= alu_fn(alu_opcode, alu_operand1, alu_operand2);
   always_ff @(posedge clock) begin
      l3_pipe[0] <= alu_fn(l3_alu_opcode, l3_alu_operand1, l3_alu_operand2);
      l3_pipe[1] <= l3_pipe[0];
      l3_pipe[2] <= l3_pipe[1];
   end
   assign l3_alu_result = l3_pipe[2];

   alu_arbiter #(.WIDTH(32), .ALU_LATENCY(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_operand1(req0_operand1), .req0_operand2(req0_operand2), .req0_opcode(req0_opcode),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_operand1(req1_operand1), .req1_operand2(req1_operand2), .req1_opcode(req1_opcode),
      .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_opcode(alu_opcode),
      .alu_result(alu_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_error(resp_error)
   );

   alu_arbiter #(.WIDTH(32), .ALU_LATENCY(3)) dut_l3 (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready),
      .req0_operand1(l3_req0_operand1), .req0_operand2(l3_req0_operand2), .req0_opcode(l3_req0_opcode),
      .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready),
      .req1_operand1(l3_req1_operand1), .req1_operand2(l3_req1_operand2), .req1_opcode(l3_req1_opcode),
      .alu_operand1(l3_alu_operand1), .alu_operand2(l3_alu_operand2), .alu_opcode(l3_alu_opcode),
      .alu_result(l3_alu_result),
      .resp_valid(l3_resp_valid), .resp_ready(l3_resp_ready), .resp_id(l3_resp_id),
      .resp_result(l3_resp_result), .resp_error(l3_resp_error)
   );

   task automatic pop_exp(output exp_t e);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 'x;
   endtask

   // Drives one request on the latency-1 instance; returns the number of
   // cycles until the grant (-1 if none). Returns #1 after the accepting edge.
   task automatic issue(input logic id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
      cyc = -1;
      @(negedge clock);
      if (id) begin
         req1_valid = 1'b1; req1_opcode = op; req1_operand1 = a; req1_operand2 = b;
      end else begin
         req0_valid = 1'b1; req0_opcode = op; req0_operand1 = a; req0_operand2 = b;
      end
      for (int i = 0; i < 20; i++) begin
         #1;
         if (id ? req1_ready : req0_ready) begin
            cyc = i;
            break;
         end
         @(negedge clock);
      end
      if (cyc >= 0) begin
         exp_q.push_back(make_exp(id, op, a, b));
         @(posedge clock);
         #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Counts edges after acceptance until resp_valid (-1 on timeout).
   task automatic wait_resp(output int cyc);
      cyc = -1;
      for (int k = 0; k < 30; k++) begin
         if (resp_valid) begin
            cyc = k;
            break;
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      tests_run++;
      if (resp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL resp_release: resp_valid=%b expected 0", resp_valid);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({resp_valid, resp_id, resp_error, resp_result, alu_operand1, alu_operand2, alu_opcode} !== '0) begin
         tests_failed++;
         $display("FAIL reset_values: valid=%b id=%b err=%b res=%h a1=%h a2=%h op=%b expected all 0",
                  resp_valid, resp_id, resp_error, resp_result, alu_operand1, alu_operand2, alu_opcode);
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n    = 1'b1;
      resp_ready = 1'b1;
      @(negedge clock);
      #1;
      tests_run++;
      if ({resp_valid, req0_ready, req1_ready} !== 3'b000) begin
         tests_failed++;
         $display("FAIL idle_after_reset: valid=%b r0=%b r1=%b expected 000", resp_valid, req0_ready, req1_ready);
      end
      resp_ready = 1'b0;
   endtask

   task automatic test_contention();
      int   grants[$];
      int   resps = 0;
      int   got_g;
      exp_t e;
      @(negedge clock);
      req0_opcode = 4'b0111; req0_operand1 = 32'd50; req0_operand2 = 32'd10;
      req1_opcode = 4'b0110; req1_operand1 = 32'd50; req1_operand2 = 32'd10;
      req0_valid  = 1'b1;
      req1_valid  = 1'b1;
      resp_ready  = 1'b1;
      for (int c = 0; c < 80 && resps < 4; c++) begin
         #1;
         if (grants.size() == 4) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            #1;
         end
         tests_run++;
         if ((req0_ready && req1_ready) || (resp_valid && (req0_ready || req1_ready))) begin
            tests_failed++;
            $display("FAIL contention_ready: r0=%b r1=%b resp_valid=%b", req0_ready, req1_ready, resp_valid);
         end
         if (req0_ready && req0_valid) begin
            grants.push_back(0);
            exp_q.push_back(make_exp(1'b0, req0_opcode, req0_operand1, req0_operand2));
         end
         if (req1_ready && req1_valid) begin
            grants.push_back(1);
            exp_q.push_back(make_exp(1'b1, req1_opcode, req1_operand1, req1_operand2));
         end
         if (resp_valid) begin
            pop_exp(e);
            resps++;
            tests_run++;
            if ({resp_id, resp_error, resp_result} !== {e.id, e.error, e.result}) begin
               tests_failed++;
               $display("FAIL contention_resp%0d: id=%b err=%b res=%0d expected id=%b err=%b res=%0d",
                        resps, resp_id, resp_error, resp_result, e.id, e.error, e.result);
            end
         end
         @(negedge clock);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp_ready = 1'b0;
      tests_run++;
      if (resps != 4) begin
         tests_failed++;
         $display("FAIL contention_count: got %0d responses expected 4", resps);
      end
      for (int i = 0; i < 4; i++) begin
         got_g = (i < grants.size()) ? grants[i] : -1;
         tests_run++;
         if (got_g != (i % 2)) begin
            tests_failed++;
            $display("FAIL contention_grant%0d: got %0d expected %0d", i, got_g, i % 2);
         end
      end
   endtask

   task automatic test_single_op();
      logic [3:0] ops [2];
      int         cyc;
      exp_t       e;
      ops[0] = 4'b0000;
      ops[1] = 4'b1000;
      for (int i = 0; i < 2; i++) begin
         issue(1'b0, ops[i], 32'd50, 32'd10, cyc);
         tests_run++;
         if (cyc != 0) begin
            tests_failed++;
            $display("FAIL single_accept op=%b: waited %0d expected 0", ops[i], cyc);
         end
         wait_resp(cyc);
         tests_run++;
         if (cyc != 2) begin
            tests_failed++;
            $display("FAIL single_latency op=%b: got %0d expected 2", ops[i], cyc);
         end
         pop_exp(e);
         tests_run++;
         if ({resp_id, resp_error, resp_result} !== {e.id, e.error, e.result}) begin
            tests_failed++;
            $display("FAIL single_resp op=%b: id=%b err=%b res=%0d expected id=%b err=%b res=%0d",
                     ops[i], resp_id, resp_error, resp_result, e.id, e.error, e.result);
         end
         finish_resp();
      end
   endtask

   task automatic test_backpressure();
      int   cyc;
      exp_t e;
      issue(1'b0, 4'b0100, 32'd50, 32'd10, cyc);
      wait_resp(cyc);
      tests_run++;
      if (cyc != 2) begin
         tests_failed++;
         $display("FAIL bp_latency: got %0d expected 2", cyc);
      end
      req1_valid = 1'b1; req1_opcode = 4'b0000; req1_operand1 = 32'd1; req1_operand2 = 32'd1;
      for (int j = 0; j < 5; j++) begin
         tests_run++;
         if ({resp_valid, resp_result, req0_ready, req1_ready} !== {1'b1, 32'd56, 2'b00}) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: valid=%b res=%0d r0=%b r1=%b expected valid=1 res=56 r0=0 r1=0",
                     j, resp_valid, resp_result, req0_ready, req1_ready);
         end
         @(posedge clock);
         #1;
      end
      req1_valid = 1'b0;
      pop_exp(e);
      tests_run++;
      if ({resp_id, resp_error, resp_result} !== {e.id, e.error, e.result}) begin
         tests_failed++;
         $display("FAIL bp_resp: id=%b err=%b res=%0d expected id=%b err=%b res=%0d",
                  resp_id, resp_error, resp_result, e.id, e.error, e.result);
      end
      finish_resp();
   endtask

   task automatic test_illegal();
      logic [3:0] ops [3];
      int         cyc;
      exp_t       e;
      ops[0] = 4'b1111;
      ops[1] = 4'b0010;
      ops[2] = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         issue((i % 2 == 0), ops[i], 32'd7, 32'd9, cyc);
         wait_resp(cyc);
         tests_run++;
         if (cyc != 0) begin
            tests_failed++;
            $display("FAIL illegal_latency op=%b: got %0d expected 0", ops[i], cyc);
         end
         pop_exp(e);
         tests_run++;
         if ({resp_id, resp_error, resp_result} !== {e.id, e.error, e.result}) begin
            tests_failed++;
            $display("FAIL illegal_resp op=%b: id=%b err=%b res=%0d expected id=%b err=%b res=%0d",
                     ops[i], resp_id, resp_error, resp_result, e.id, e.error, e.result);
         end
         tests_run++;
         if ({alu_operand1, alu_operand2, alu_opcode} !== {32'd50, 32'd10, 4'b0100}) begin
            tests_failed++;
            $display("FAIL illegal_alu_hold: a1=%0d a2=%0d op=%b expected 50 10 0100",
                     alu_operand1, alu_operand2, alu_opcode);
         end
         finish_resp();
      end
   endtask

   task automatic test_reset_mid_exec();
      int   cyc;
      exp_t e;
      issue(1'b0, 4'b0000, 32'd50, 32'd10, cyc);
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      tests_run++;
      if ({resp_valid, resp_id, resp_error, resp_result, alu_operand1, alu_operand2, alu_opcode} !== '0) begin
         tests_failed++;
         $display("FAIL abort_reset: valid=%b id=%b err=%b res=%h a1=%h a2=%h op=%b expected all 0",
                  resp_valid, resp_id, resp_error, resp_result, alu_operand1, alu_operand2, alu_opcode);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clock);
         tests_run++;
         if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_stale%0d: resp_valid=%b expected 0", j, resp_valid);
         end
      end
      req0_opcode = 4'b0111; req0_operand1 = 32'd50; req0_operand2 = 32'd10;
      req1_opcode = 4'b0110; req1_operand1 = 32'd50; req1_operand2 = 32'd10;
      req0_valid  = 1'b1;
      req1_valid  = 1'b1;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL abort_tie: r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
      end
      if (req0_ready) exp_q.push_back(make_exp(1'b0, 4'b0111, 32'd50, 32'd10));
      if (req1_ready) exp_q.push_back(make_exp(1'b1, 4'b0110, 32'd50, 32'd10));
      @(posedge clock);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_resp(cyc);
      pop_exp(e);
      tests_run++;
      if ({resp_id, resp_error, resp_result} !== {1'b0, 1'b0, 32'd2}) begin
         tests_failed++;
         $display("FAIL abort_tie_resp: id=%b err=%b res=%0d expected id=0 err=0 res=2",
                  resp_id, resp_error, resp_result);
      end
      finish_resp();
   endtask

   task automatic test_latency_param();
      logic        ids [3];
      logic [3:0]  ops [3];
      logic [31:0] as  [3];
      logic [31:0] bs  [3];
      int          cyc;
      logic        rdy;
      exp_t        e;
      ids[0] = 1'b0; ops[0] = 4'b0101; as[0] = 32'h8000_0000; bs[0] = 32'd4;
      ids[1] = 1'b1; ops[1] = 4'b0001; as[1] = 32'd3;         bs[1] = 32'd5;
      ids[2] = 1'b0; ops[2] = 4'b1000; as[2] = 32'd10;        bs[2] = 32'd50;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (ids[i]) begin
            l3_req1_valid = 1'b1; l3_req1_opcode = ops[i]; l3_req1_operand1 = as[i]; l3_req1_operand2 = bs[i];
         end else begin
            l3_req0_valid = 1'b1; l3_req0_opcode = ops[i]; l3_req0_operand1 = as[i]; l3_req0_operand2 = bs[i];
         end
         #1;
         rdy = ids[i] ? l3_req1_ready : l3_req0_ready;
         tests_run++;
         if (rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL l3_accept%0d: ready=%b expected 1", i, rdy);
         end
         exp_q.push_back(make_exp(ids[i], ops[i], as[i], bs[i]));
         @(posedge clock);
         #1;
         l3_req0_valid = 1'b0;
         l3_req1_valid = 1'b0;
         cyc = -1;
         for (int k = 0; k < 30; k++) begin
            if (l3_resp_valid) begin
               cyc = k;
               break;
            end
            @(posedge clock);
            #1;
         end
         tests_run++;
         if (cyc != 4) begin
            tests_failed++;
            $display("FAIL l3_latency%0d: got %0d expected 4", i, cyc);
         end
         pop_exp(e);
         tests_run++;
         if ({l3_resp_id, l3_resp_error, l3_resp_result} !== {e.id, e.error, e.result}) begin
            tests_failed++;
            $display("FAIL l3_resp%0d: id=%b err=%b res=%h expected id=%b err=%b res=%h",
                     i, l3_resp_id, l3_resp_error, l3_resp_result, e.id, e.error, e.result);
         end
         l3_resp_ready = 1'b1;
         @(posedge clock);
         #1;
         l3_resp_ready = 1'b0;
      end
   endtask

   initial begin
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
      req0_opcode = '0; req0_operand1 = '0; req0_operand2 = '0;
      req1_opcode = '0; req1_operand1 = '0; req1_operand2 = '0;
      l3_req0_valid = 1'b0; l3_req1_valid = 1'b0; l3_resp_ready = 1'b0;
      l3_req0_opcode = '0; l3_req0_operand1 = '0; l3_req0_operand2 = '0;
      l3_req1_opcode = '0; l3_req1_operand1 = '0; l3_req1_operand2 = '0;
      test_reset();
      test_contention();
      test_single_op();
      test_backpressure();
      test_illegal();
      test_reset_mid_exec();
      test_latency_param();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
